// File: rtl/adder_multicycle_pkg.sv
// adder_multicycle_pkg: FSM state encoding and counter sizing helper for the multi-cycle adder
package adder_multicycle_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;
    function automatic int cnt_width(input int steps);
        int w;
        w = 1;
        while ((1 << w) < steps) w++;
        return w;
    endfunction
endpackage

// File: rtl/adder_multicycle_chunk.sv
// adder_chunk: combinational ripple-carry adder built from full-adder cells
//   a_i, b_i : chunk operands
//   cin_i    : carry in
//   sum_o    : chunk sum
//   cout_o   : carry out of the chunk MSB
module adder_chunk #(
    parameter int p_nbits = 8
) (
    input  logic [p_nbits-1:0] a_i,
    input  logic [p_nbits-1:0] b_i,
    input  logic               cin_i,
    output logic [p_nbits-1:0] sum_o,
    output logic               cout_o
);
    logic [p_nbits:0] c;
    assign c[0] = cin_i;
    for (genvar i = 0; i < p_nbits; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign cout_o = c[p_nbits];
endmodule

// File: rtl/adder_multicycle.sv
// adder_multicycle: val/rdy multi-cycle adder, p_nbits_per_step bits per cycle
//   clk, reset        : clock, synchronous active-high reset
//   in_val/in_rdy     : operand handshake, in_a/in_b latched on acceptance
//   in_sub            : only with ADDER_MULTICYCLE_SUB_EN; computes A + ~B + 1
//   out_val/out_rdy   : result handshake
//   out_sum/out_cout  : (A+B) mod 2^p_nbits and carry out of the MSB
// One shared chunk adder is walked across the operands; the carry between
// chunks lives in carry_q. out_val is registered one cycle after DONE entry.
module adder_multicycle
    import adder_multicycle_pkg::*;
#(
    parameter int p_nbits          = 32,
    parameter int p_nbits_per_step = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_a,
    input  logic [p_nbits-1:0] in_b,
`ifdef ADDER_MULTICYCLE_SUB_EN
    input  logic               in_sub,
`endif
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_sum,
    output logic               out_cout
);
    localparam int K     = p_nbits_per_step;
    localparam int STEPS = p_nbits / K;
    localparam int CW    = cnt_width(STEPS);

    if (p_nbits % K != 0) begin : g_bad_cfg
        $error("adder_multicycle: p_nbits_per_step must divide p_nbits");
    end

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               carry_q;
    logic               sub_q;
    logic               sub_d;
    logic [p_nbits-1:0] a_q;
    logic [p_nbits-1:0] b_q;
    logic [p_nbits-1:0] sum_q;
    logic               cout_q;
    logic               in_rdy_q;
    logic               out_val_q;
    logic [K-1:0]       chunk_a;
    logic [K-1:0]       chunk_b;
    logic [K-1:0]       chunk_sum;
    logic               chunk_cout;

`ifdef ADDER_MULTICYCLE_SUB_EN
    assign sub_d = in_sub;
`else
    assign sub_d = 1'b0;
`endif

    assign cnt_d   = cnt_q + 1'b1;
    assign chunk_a = a_q[int'(cnt_q)*K +: K];
    // Subtraction inverts B; the +1 comes from the carry register's initial value
    assign chunk_b = b_q[int'(cnt_q)*K +: K] ^ {K{sub_q}};

    adder_chunk #(.p_nbits(K)) u_chunk (
        .a_i   (chunk_a),
        .b_i   (chunk_b),
        .cin_i (carry_q),
        .sum_o (chunk_sum),
        .cout_o(chunk_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_val && in_rdy_q) begin
                    a_q      <= in_a;
                    b_q      <= in_b;
                    sub_q    <= sub_d;
                    carry_q  <= sub_d;
                    cnt_q    <= '0;
                    in_rdy_q <= 1'b0;
                    state_q  <= CALC;
                end
                CALC: begin
                    sum_q[int'(cnt_q)*K +: K] <= chunk_sum;
                    carry_q <= chunk_cout;
                    cnt_q   <= cnt_d;
                    if (cnt_q == CW'(STEPS - 1)) begin
                        cout_q  <= chunk_cout;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_val_q && out_rdy) begin
                    out_val_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    state_q   <= IDLE;
                end else begin
                    out_val_q <= 1'b1;
                end
                default: begin
                    out_val_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign in_rdy   = in_rdy_q;
    assign out_val  = out_val_q;
    assign out_sum  = sum_q;
    assign out_cout = cout_q;
endmodule

// File: tb/tb_adder_multicycle.sv
// tb_adder_multicycle: directed vector table, multi-cycle corner sequences and random stall traffic
module tb_adder_multicycle;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_val = 1'b0;
    logic       in_rdy;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_sub = 1'b0;
    logic       out_val;
    logic       out_rdy = 1'b0;
    logic [7:0] out_sum;
    logic       out_cout;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    adder_multicycle #(.p_nbits(8), .p_nbits_per_step(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_a    (in_a),
        .in_b    (in_b),
`ifdef ADDER_MULTICYCLE_SUB_EN
        .in_sub  (in_sub),
`endif
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_sum (out_sum),
        .out_cout(out_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Presents operands and returns at the first negedge after the accepting edge
    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic s);
        int k;
        k = 0;
        in_a = a;
        in_b = b;
        in_sub = s;
        in_val = 1'b1;
        while (!in_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("accept_timeout", 32'(k), 0);
        @(negedge clk);
        in_val = 1'b0;
        in_a = ~a;
        in_b = 8'($urandom);
        in_sub = ~s;
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (!out_val && k < 50) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] es, input logic ec);
        int k;
        out_rdy = 1'b1;
        accept(a, b, s);
        chk("busy_in_rdy", 32'(in_rdy), 0);
        wait_out(k);
        chk("latency", 32'(k), 5);
        chk("sum", 32'(out_sum), 32'(es));
        chk("cout", 32'(out_cout), 32'(ec));
        @(negedge clk);
        chk("release", 32'({in_rdy, out_val}), 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int k;
        int done_cnt;
        logic [7:0] a, b;
        logic s;
        logic [8:0] exp9;
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[7] = '{8'h2D, 8'h2D, 1'b0, 8'h5A, 1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", 32'(in_rdy), 1);
        chk("rst_out_val", 32'(out_val), 0);
        chk("rst_sum", 32'(out_sum), 0);
        chk("rst_cout", 32'(out_cout), 0);

        for (int i = 0; i < 8; i++)
            txn(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout);

        // Backpressure: result must hold while out_rdy is low, new requests ignored
        out_rdy = 1'b0;
        accept(8'h2D, 8'h2D, 1'b0);
        wait_out(k);
        chk("bp_latency", 32'(k), 5);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_val", 32'(out_val), 1);
            chk("bp_sum", 32'(out_sum), 32'h5A);
            chk("bp_cout", 32'(out_cout), 0);
            chk("bp_in_rdy", 32'(in_rdy), 0);
            in_val = 1'b1;
            in_a = 8'($urandom);
            @(negedge clk);
        end
        in_val = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'({in_rdy, out_val}), 2);

        // Reset two cycles into CALC discards the transaction
        accept(8'hAA, 8'h55, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        in_val = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        in_val = 1'b0;
        chk("midrst_state", 32'({in_rdy, out_val}), 2);
        chk("midrst_sum", 32'(out_sum), 0);
        repeat (8) @(negedge clk);
        chk("midrst_no_result", 32'(out_val), 0);
        txn(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Reset wins over a simultaneous handshake in IDLE
        in_a = 8'h01;
        in_b = 8'h01;
        in_val = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        in_val = 1'b0;
        chk("rst_prio_in_rdy", 32'(in_rdy), 1);
        repeat (7) @(negedge clk);
        chk("rst_prio_out_val", 32'(out_val), 0);

`ifdef ADDER_MULTICYCLE_SUB_EN
        txn(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
        txn(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        txn(8'h05, 8'h05, 1'b1, 8'h00, 1'b1);
`endif

        // Random traffic with input gaps and output stalls
        done_cnt = 0;
        for (int t = 0; t < 200; t++) begin
            a = 8'($urandom);
            b = 8'($urandom);
`ifdef ADDER_MULTICYCLE_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            exp9 = s ? {1'b0, a} + {1'b0, ~b} + 9'd1 : {1'b0, a} + {1'b0, b};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            accept(a, b, s);
            k = 0;
            out_rdy = 1'($urandom_range(0, 1));
            while (!(out_val && out_rdy) && k < 100) begin
                @(negedge clk);
                out_rdy = 1'($urandom_range(0, 1));
                k++;
            end
            if (k >= 100) chk("rnd_timeout", 32'(k), 0);
            else begin
                done_cnt++;
                if ({out_cout, out_sum} !== exp9) chk("rnd_result", 32'({out_cout, out_sum}), 32'(exp9));
            end
            @(negedge clk);
            if (out_val !== 1'b0) chk("rnd_dup", 32'(out_val), 0);
        end
        chk("rnd_count", 32'(done_cnt), 200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
